// File: rtl/ysyx_22050710_mc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_mc_seq_if
// Brief    : Fetch and load/store bus bundle between sequencer and memory side.
// Revision : 1.0
// ============================================================================
interface ysyx_22050710_mc_seq_if #(
    parameter int XLEN = 64
);
    // instruction fetch channel
    logic            o_if_valid;
    logic            i_if_ready;
    logic            i_if_rvalid;
    logic [31:0]     i_if_rdata;
    logic            i_if_err;
    // data load/store channel
    logic            o_ls_valid;
    logic            o_ls_wen;
    logic [XLEN-1:0] o_ls_addr;
    logic [XLEN-1:0] o_ls_wdata;
    logic            i_ls_ready;
    logic            i_ls_rvalid;
    logic [XLEN-1:0] i_ls_rdata;
    logic            i_ls_err;

    modport master (
        output o_if_valid,
        input  i_if_ready, i_if_rvalid, i_if_rdata, i_if_err,
        output o_ls_valid, o_ls_wen, o_ls_addr, o_ls_wdata,
        input  i_ls_ready, i_ls_rvalid, i_ls_rdata, i_ls_err
    );

    modport slave (
        input  o_if_valid,
        output i_if_ready, i_if_rvalid, i_if_rdata, i_if_err,
        input  o_ls_valid, o_ls_wen, o_ls_addr, o_ls_wdata,
        output i_ls_ready, i_ls_rvalid, i_ls_rdata, i_ls_err
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050710_mc_seq.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_mc_seq
// Brief    : Multi-cycle core sequencer: fetch, execute, memory, writeback.
// Revision : 1.0
// ============================================================================
module ysyx_22050710_mc_seq #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rst,
    ysyx_22050710_mc_seq_if.master    bus,
    input  wire logic [1:0]           i_memop,
    input  wire logic                 i_is_invalid,
    input  wire logic [XLEN-1:0]      i_alu_result,
    input  wire logic [XLEN-1:0]      i_store_data,
    input  wire logic [XLEN-1:0]      i_nextpc,
    input  wire logic                 i_sys_change_pc,
    input  wire logic [XLEN-1:0]      i_sysctr_pc,
    output logic      [XLEN-1:0]      o_pc,
    output logic      [31:0]          o_inst,
    output logic      [XLEN-1:0]      o_ld_data,
    output logic                      o_commit,
    output logic                      o_halt,
    output logic      [1:0]           o_halt_cause,
    output logic      [63:0]          o_instret
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_IWAIT = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_MWAIT = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;

    localparam logic [1:0] c_memop_load   = 2'b01;
    localparam logic [1:0] c_memop_store  = 2'b10;
    localparam logic [1:0] c_memop_rsvd   = 2'b11;
    localparam logic [1:0] c_cause_ill    = 2'd1;
    localparam logic [1:0] c_cause_ifetch = 2'd2;
    localparam logic [1:0] c_cause_data   = 2'd3;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_ld_data;
    logic [63:0]     r_instret;
    logic [1:0]      r_halt_cause;
    logic            r_ls_wen;
    logic [XLEN-1:0] r_ls_addr;
    logic [XLEN-1:0] r_ls_wdata;

    logic w_pc_misaligned;
    logic w_illegal;
    logic w_is_mem;

    assign w_pc_misaligned = (r_pc[1:0] != 2'b00);
    assign w_illegal       = i_is_invalid || (i_memop == c_memop_rsvd);
    assign w_is_mem        = (i_memop == c_memop_load) || (i_memop == c_memop_store);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                // A misaligned PC never reaches the bus
                if (w_pc_misaligned) begin
                    w_next_state = S_HALT;
                end else if (bus.i_if_ready) begin
                    w_next_state = S_IWAIT;
                end
            end
            S_IWAIT: begin
                if (bus.i_if_rvalid) begin
                    w_next_state = bus.i_if_err ? S_HALT : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_illegal) begin
                    w_next_state = S_HALT;
                end else if (w_is_mem) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                if (bus.i_ls_ready) begin
                    w_next_state = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (bus.i_ls_rvalid) begin
                    w_next_state = bus.i_ls_err ? S_HALT : S_WB;
                end
            end
            S_WB:    w_next_state = S_FETCH;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.o_if_valid = 1'b0;
        bus.o_ls_valid = 1'b0;
        o_commit       = 1'b0;
        o_halt         = 1'b0;
        case (r_state)
            S_FETCH: bus.o_if_valid = !w_pc_misaligned;
            S_MEM:   bus.o_ls_valid = 1'b1;
            S_WB:    o_commit       = 1'b1;
            S_HALT:  o_halt         = 1'b1;
            default: begin
                bus.o_if_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Architectural and bus-request registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= RESET_PC;
            r_inst       <= 32'd0;
            r_ld_data    <= '0;
            r_instret    <= 64'd0;
            r_halt_cause <= 2'd0;
            r_ls_wen     <= 1'b0;
            r_ls_addr    <= '0;
            r_ls_wdata   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_pc_misaligned) begin
                        r_halt_cause <= c_cause_data;
                    end
                end
                S_IWAIT: begin
                    if (bus.i_if_rvalid) begin
                        r_inst <= bus.i_if_rdata;
                        if (bus.i_if_err) begin
                            r_halt_cause <= c_cause_ifetch;
                        end
                    end
                end
                S_EXEC: begin
                    // Request is frozen here so the decoder may move on during MEM
                    if (w_illegal) begin
                        r_halt_cause <= c_cause_ill;
                    end else if (w_is_mem) begin
                        r_ls_wen   <= (i_memop == c_memop_store);
                        r_ls_addr  <= i_alu_result;
                        r_ls_wdata <= i_store_data;
                    end
                end
                S_MWAIT: begin
                    if (bus.i_ls_rvalid) begin
                        if (!r_ls_wen) begin
                            r_ld_data <= bus.i_ls_rdata;
                        end
                        if (bus.i_ls_err) begin
                            r_halt_cause <= c_cause_data;
                        end
                    end
                end
                S_WB: begin
                    r_pc      <= i_sys_change_pc ? i_sysctr_pc : i_nextpc;
                    r_instret <= r_instret + 64'd1;
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    assign bus.o_ls_wen   = r_ls_wen;
    assign bus.o_ls_addr  = r_ls_addr;
    assign bus.o_ls_wdata = r_ls_wdata;
    assign o_pc           = r_pc;
    assign o_inst         = r_inst;
    assign o_ld_data      = r_ld_data;
    assign o_instret      = r_instret;
    assign o_halt_cause   = r_halt_cause;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_mc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050710_mc_seq
// Brief    : Directed plus randomized bench for the multi-cycle sequencer.
// Revision : 1.0
// ============================================================================
module tb_ysyx_22050710_mc_seq;

    localparam logic [63:0] c_reset_pc = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_memop;
    logic        i_is_invalid;
    logic [63:0] i_alu_result;
    logic [63:0] i_store_data;
    logic [63:0] i_nextpc;
    logic        i_sys_change_pc;
    logic [63:0] i_sysctr_pc;
    logic [63:0] o_pc;
    logic [31:0] o_inst;
    logic [63:0] o_ld_data;
    logic        o_commit;
    logic        o_halt;
    logic [1:0]  o_halt_cause;
    logic [63:0] o_instret;

    int checks = 0;
    int errors = 0;

    // reference state: architectural effect of each instruction
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    logic [63:0] m_ld;
    logic [63:0] m_instret;
    logic        m_halt;
    logic [1:0]  m_cause;

    ysyx_22050710_mc_seq_if #(.XLEN(64)) bus ();

    ysyx_22050710_mc_seq #(.XLEN(64), .RESET_PC(c_reset_pc)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .bus             (bus),
        .i_memop         (i_memop),
        .i_is_invalid    (i_is_invalid),
        .i_alu_result    (i_alu_result),
        .i_store_data    (i_store_data),
        .i_nextpc        (i_nextpc),
        .i_sys_change_pc (i_sys_change_pc),
        .i_sysctr_pc     (i_sysctr_pc),
        .o_pc            (o_pc),
        .o_inst          (o_inst),
        .o_ld_data       (o_ld_data),
        .o_commit        (o_commit),
        .o_halt          (o_halt),
        .o_halt_cause    (o_halt_cause),
        .o_instret       (o_instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_arch(input string tag);
        chk({tag, "_pc"},      o_pc,               m_pc);
        chk({tag, "_inst"},    64'(o_inst),        64'(m_inst));
        chk({tag, "_ld"},      o_ld_data,          m_ld);
        chk({tag, "_instret"}, o_instret,          m_instret);
        chk({tag, "_halt"},    64'(o_halt),        64'(m_halt));
        chk({tag, "_cause"},   64'(o_halt_cause),  64'(m_cause));
    endtask

    task automatic model_reset();
        m_pc = c_reset_pc; m_inst = 32'd0; m_ld = 64'd0;
        m_instret = 64'd0; m_halt = 1'b0; m_cause = 2'd0;
    endtask

    task automatic idle_bus();
        bus.i_if_ready = 1'b0; bus.i_if_rvalid = 1'b0; bus.i_if_rdata = 32'd0; bus.i_if_err = 1'b0;
        bus.i_ls_ready = 1'b0; bus.i_ls_rvalid = 1'b0; bus.i_ls_rdata = 64'd0; bus.i_ls_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        // junk everywhere: reset must dominate
        bus.i_if_ready = 1'b1; bus.i_if_rvalid = 1'b1; bus.i_if_err = 1'b1;
        bus.i_ls_ready = 1'b1; bus.i_ls_rvalid = 1'b1; bus.i_ls_err = 1'b1;
        bus.i_ls_rdata = {$urandom, $urandom}; i_sys_change_pc = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle_bus();
        i_sys_change_pc = 1'b0;
        model_reset();
        check_arch("reset");
        chk("reset_if_valid", 64'(bus.o_if_valid), 64'd1);
        chk("reset_ls_valid", 64'(bus.o_ls_valid), 64'd0);
        chk("reset_commit",   64'(o_commit),       64'd0);
    endtask

    task automatic poke_halted(input int n);
        repeat (n) begin
            bus.i_if_ready = 1'($urandom); bus.i_if_rvalid = 1'($urandom);
            bus.i_if_rdata = $urandom;     bus.i_if_err    = 1'($urandom);
            bus.i_ls_ready = 1'($urandom); bus.i_ls_rvalid = 1'($urandom);
            bus.i_ls_rdata = {$urandom, $urandom}; bus.i_ls_err = 1'($urandom);
            i_sys_change_pc = 1'($urandom);
            tick();
            chk("halt_if_valid", 64'(bus.o_if_valid), 64'd0);
            chk("halt_ls_valid", 64'(bus.o_ls_valid), 64'd0);
            chk("halt_commit",   64'(o_commit),       64'd0);
            check_arch("halt_frozen");
        end
        idle_bus();
        i_sys_change_pc = 1'b0;
    endtask

    // One instruction from FETCH; wa/wb fetch ready/response waits, wc/wd data waits.
    task automatic do_instr(input logic [31:0] inst, input logic [1:0] memop, input bit invalid,
                            input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                            input logic [63:0] nextpc, input bit chg, input logic [63:0] tgt,
                            input int wa, input int wb, input int wc, input int wd,
                            input bit if_err, input bit ls_err, input bit rst_mwait);
        int  cyc = 0;
        bit  is_mem = (memop == 2'b01) || (memop == 2'b10);
        i_memop = memop; i_is_invalid = invalid; i_alu_result = addr; i_store_data = wdata;
        i_nextpc = nextpc; i_sys_change_pc = chg; i_sysctr_pc = tgt;

        if (m_pc[1:0] != 2'b00) begin
            chk("misalign_if_valid", 64'(bus.o_if_valid), 64'd0);
            bus.i_if_ready = 1'b1;
            tick();
            bus.i_if_ready = 1'b0;
            m_halt = 1'b1; m_cause = 2'd3;
            chk("misalign_if_valid_after", 64'(bus.o_if_valid), 64'd0);
            check_arch("misalign");
            return;
        end

        chk("fetch_valid", 64'(bus.o_if_valid), 64'd1);
        chk("fetch_pc",    o_pc,                m_pc);
        repeat (wa) begin
            bus.i_if_rvalid = 1'($urandom); bus.i_if_rdata = $urandom;
            tick(); cyc++;
            chk("fetch_hold", 64'(bus.o_if_valid), 64'd1);
        end
        bus.i_if_rvalid = 1'b0; bus.i_if_ready = 1'b1;
        tick(); cyc++;
        bus.i_if_ready = 1'b0;
        chk("iwait_valid", 64'(bus.o_if_valid), 64'd0);
        repeat (wb) begin
            bus.i_if_ready = 1'($urandom);
            tick(); cyc++;
            chk("iwait_hold", 64'(bus.o_if_valid), 64'd0);
        end
        bus.i_if_ready = 1'b0; bus.i_if_rvalid = 1'b1; bus.i_if_rdata = inst; bus.i_if_err = if_err;
        tick(); cyc++;
        bus.i_if_rvalid = 1'b0; bus.i_if_err = 1'b0;
        if (if_err) begin
            m_halt = 1'b1; m_cause = 2'd2;
            chk("iferr_halt",    64'(o_halt),       64'd1);
            chk("iferr_cause",   64'(o_halt_cause), 64'd2);
            chk("iferr_pc",      o_pc,              m_pc);
            chk("iferr_instret", o_instret,         m_instret);
            m_inst = o_inst; // capture policy on an erroring response is left open
            return;
        end
        m_inst = inst;
        chk("exec_inst", 64'(o_inst), 64'(m_inst));
        tick(); cyc++;
        if (invalid || memop == 2'b11) begin
            m_halt = 1'b1; m_cause = 2'd1;
            check_arch("illegal");
            return;
        end
        if (is_mem) begin
            chk("mem_valid", 64'(bus.o_ls_valid), 64'd1);
            chk("mem_addr",  bus.o_ls_addr,       addr);
            chk("mem_wdata", bus.o_ls_wdata,      wdata);
            chk("mem_wen",   64'(bus.o_ls_wen),   64'(memop == 2'b10));
            repeat (wc) begin
                i_alu_result = {$urandom, $urandom}; i_store_data = {$urandom, $urandom};
                bus.i_ls_rvalid = 1'($urandom);
                tick(); cyc++;
                chk("mem_hold_valid", 64'(bus.o_ls_valid), 64'd1);
                chk("mem_hold_addr",  bus.o_ls_addr,       addr);
                chk("mem_hold_wdata", bus.o_ls_wdata,      wdata);
            end
            bus.i_ls_rvalid = 1'b0; bus.i_ls_ready = 1'b1;
            tick(); cyc++;
            bus.i_ls_ready = 1'b0;
            chk("mwait_valid", 64'(bus.o_ls_valid), 64'd0);
            repeat (wd) begin
                bus.i_ls_ready = 1'($urandom);
                tick(); cyc++;
            end
            bus.i_ls_ready = 1'b0; bus.i_ls_rvalid = 1'b1; bus.i_ls_rdata = rdata; bus.i_ls_err = ls_err;
            if (rst_mwait) rst = 1'b1;
            tick(); cyc++;
            bus.i_ls_rvalid = 1'b0; bus.i_ls_err = 1'b0;
            if (rst_mwait) begin
                rst = 1'b0;
                model_reset();
                check_arch("rst_mwait");
                chk("rst_mwait_if_valid", 64'(bus.o_if_valid), 64'd1);
                chk("rst_mwait_commit",   64'(o_commit),       64'd0);
                return;
            end
            if (ls_err) begin
                if (memop == 2'b01) m_ld = rdata;
                m_halt = 1'b1; m_cause = 2'd3;
                check_arch("lserr");
                return;
            end
            if (memop == 2'b01) m_ld = rdata;
            chk("ld_data", o_ld_data, m_ld);
        end
        chk("wb_commit", 64'(o_commit), 64'd1);
        chk("wb_pc",     o_pc,          m_pc);
        tick(); cyc++;
        m_pc = chg ? tgt : nextpc;
        m_instret = m_instret + 64'd1;
        chk("post_commit", 64'(o_commit), 64'd0);
        check_arch("retire");
        chk("latency", 64'(cyc), 64'(4 + wa + wb + (is_mem ? 2 + wc + wd : 0)));
    endtask

    initial begin
        rst = 1'b1;
        idle_bus();
        i_memop = 2'b00; i_is_invalid = 1'b0; i_alu_result = 64'd0; i_store_data = 64'd0;
        i_nextpc = 64'd0; i_sys_change_pc = 1'b0; i_sysctr_pc = 64'd0;
        model_reset();

        do_reset();

        // zero-wait addi stream
        for (int i = 0; i < 4; i++)
            do_instr(32'h0010_0093, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0, m_pc + 64'd4, 1'b0, 64'd0,
                     0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // load with delayed ready, then a store
        do_instr(32'h0000_b103, 2'b01, 1'b0, 64'h8000_1000, 64'd0, 64'hdead_beef_cafe_f00d,
                 m_pc + 64'd4, 1'b0, 64'd0, 0, 0, 3, 0, 1'b0, 1'b0, 1'b0);
        do_instr(32'h0020_b023, 2'b10, 1'b0, 64'h8000_2008, 64'h1234_5678_9abc_def0, 64'h5555,
                 m_pc + 64'd4, 1'b0, 64'd0, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0);

        // CSR redirect overrides next PC
        do_instr(32'h0000_0073, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0, 64'h8000_0004, 1'b1,
                 64'h8000_0100, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  mop;
            logic [63:0] npc;
            mop = 2'($urandom_range(0, 2));
            npc = ($urandom_range(0, 3) == 0) ? ({$urandom, $urandom} & ~64'h3) : m_pc + 64'd4;
            do_instr($urandom, mop, 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, npc, ($urandom_range(0, 3) == 0),
                     {$urandom, $urandom} & ~64'h3,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        end

        // reset during MWAIT with a response present
        do_reset();
        do_instr(32'h0000_b103, 2'b01, 1'b0, 64'h8000_3000, 64'd0, 64'hffff_0000_ffff_0000,
                 m_pc + 64'd4, 1'b0, 64'd0, 0, 0, 1, 1, 1'b0, 1'b0, 1'b1);

        // fetch bus error
        do_instr(32'h0010_0093, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0, m_pc + 64'd4, 1'b0, 64'd0,
                 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr(32'h0010_0093, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0, m_pc + 64'd4, 1'b0, 64'd0,
                 1, 2, 0, 0, 1'b1, 1'b0, 1'b0);
        poke_halted(6);
        do_reset();

        // misaligned next PC
        do_instr(32'h0010_0093, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0, 64'h8000_0002, 1'b0, 64'd0,
                 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_instr(32'h0010_0093, 2'b00, 1'b0, 64'd0, 64'd0, 64'd0, 64'h8000_0006, 1'b0, 64'd0,
                 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        poke_halted(3);
        do_reset();

        // illegal instruction and reserved memop
        do_instr(32'hffff_ffff, 2'b00, 1'b1, 64'd0, 64'd0, 64'd0, m_pc + 64'd4, 1'b0, 64'd0,
                 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        poke_halted(3);
        do_reset();
        do_instr(32'h0000_0003, 2'b11, 1'b0, 64'd0, 64'd0, 64'd0, m_pc + 64'd4, 1'b0, 64'd0,
                 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // data bus error on a store
        do_instr(32'h0020_b023, 2'b10, 1'b0, 64'h8000_4000, 64'habcd, 64'd0, m_pc + 64'd4,
                 1'b0, 64'd0, 1, 0, 1, 1, 1'b0, 1'b1, 1'b0);
        poke_halted(3);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
